// File: rtl/mult_pkg.sv
// Shared constants and helpers for the multiplier pipeline controller.
package mult_pkg;

  localparam int unsigned MULT_STAGES = 3;
  localparam int unsigned MULT_CNT_W  = 16;
  localparam int unsigned MULT_TAG_W  = 4;

  // Number of set valid bits across the pipeline.
  function automatic logic [1:0] occ_count(input logic [MULT_STAGES-1:0] v);
    logic [1:0] sum;
    sum = '0;
    for (int i = 0; i < int'(MULT_STAGES); i++) begin
      sum = sum + {1'b0, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/mult_vld_stage.sv
// One pipeline slot: a valid bit plus the sideband tag travelling with it.
// Load takes priority over clear so a slot refilled in the same cycle it drains stays valid.
module mult_vld_stage
  import mult_pkg::*;
#(
  parameter int unsigned TAG_W = MULT_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             vin,
  input  logic [TAG_W-1:0] tin,
  output logic             vout,
  output logic [TAG_W-1:0] tout
);

  logic             v_q;
  logic [TAG_W-1:0] t_q;

  // Valid/tag register; tags are only ever overwritten by a load, never cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= 1'b0;
      t_q <= '0;
    end else if (load) begin
      v_q <= vin;
      t_q <= tin;
    end else if (clear) begin
      v_q <= 1'b0;
    end
  end

  assign vout = v_q;
  assign tout = t_q;

endmodule

// File: rtl/mult_pipe_ctrl.sv
// Pipeline controller for the 3-stage registered 4x4 multiplier.
// Generates the in_en / s_en / out_en register enables from a valid/ready handshake on both
// ends and carries a sideband tag alongside each operand pair.
// Optional statistics counters are built when MULT_CTRL_STATS_EN is defined.
module mult_pipe_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned TAG_W = MULT_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  in_en,
  output logic                  s_en,
  output logic                  out_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TAG_W-1:0]      out_tag,
  output logic [1:0]            occ,
  output logic [MULT_CNT_W-1:0] acc_cnt,
  output logic [MULT_CNT_W-1:0] done_cnt
);

  logic             v0, v1, v2;
  logic [TAG_W-1:0] t0, t1, t2;
  logic             adv1, adv2;

  // Ready chain runs from the output back to the input; in_ready never looks at in_valid.
  always_comb begin
    adv2     = !v2 | out_ready;
    adv1     = !v1 | adv2;
    out_en   = !flush & v1 & adv2;
    s_en     = !flush & v0 & adv1;
    in_ready = !flush & (!v0 | adv1);
    in_en    = in_valid & in_ready;
  end

  mult_vld_stage #(
    .TAG_W (TAG_W)
  ) u_stage0 (
    .clk   (clk),
    .rst   (rst),
    .load  (in_en),
    .clear (flush | s_en),
    .vin   (1'b1),
    .tin   (in_tag),
    .vout  (v0),
    .tout  (t0)
  );

  mult_vld_stage #(
    .TAG_W (TAG_W)
  ) u_stage1 (
    .clk   (clk),
    .rst   (rst),
    .load  (s_en),
    .clear (flush | out_en),
    .vin   (v0),
    .tin   (t0),
    .vout  (v1),
    .tout  (t1)
  );

  // Output slot empties when the consumer takes the product and nothing replaces it.
  mult_vld_stage #(
    .TAG_W (TAG_W)
  ) u_stage2 (
    .clk   (clk),
    .rst   (rst),
    .load  (out_en),
    .clear (flush | out_ready),
    .vin   (v1),
    .tin   (t1),
    .vout  (v2),
    .tout  (t2)
  );

  assign out_valid = v2;
  assign out_tag   = t2;
  assign occ       = occ_count({v2, v1, v0});

`ifdef MULT_CTRL_STATS_EN
  logic [MULT_CNT_W-1:0] acc_q, done_q;

  // Transaction counters; survive flush, cleared only by reset, wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      done_q <= '0;
    end else begin
      if (in_en) begin
        acc_q <= acc_q + MULT_CNT_W'(1);
      end
      if (out_valid && out_ready) begin
        done_q <= done_q + MULT_CNT_W'(1);
      end
    end
  end

  assign acc_cnt  = acc_q;
  assign done_cnt = done_q;
`else
  assign acc_cnt  = '0;
  assign done_cnt = '0;
`endif

endmodule

// File: tb/tb_mult_pipe_ctrl.sv
// Self-checking bench for mult_pipe_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a slot/queue model of the pipeline.
module tb_mult_pipe_ctrl;
  import mult_pkg::*;

  localparam int unsigned TW = 4;
`ifdef MULT_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, in_en, s_en, out_en, out_valid;
  logic [TW-1:0] out_tag;
  logic [1:0]    occ;
  logic [15:0]   acc_cnt, done_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mult_pipe_ctrl #(
    .TAG_W (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .in_en     (in_en),
    .s_en      (s_en),
    .out_en    (out_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .occ       (occ),
    .acc_cnt   (acc_cnt),
    .done_cnt  (done_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Three slots (0 = input regs, 2 = output reg) plus an in-order queue of tags in flight.
  logic [2:0]    mv = '0;
  logic [TW-1:0] mt [3];
  logic [15:0]   macc = '0;
  logic [15:0]   mdone = '0;
  logic [TW-1:0] sb [$];
  logic          e_free0, e_free1, e_free2;
  logic          e_in_ready, e_in_en, e_s_en, e_out_en;
  logic [1:0]    e_occ;

  // A slot frees up when it is empty or its content moves forward this cycle.
  always_comb begin
    e_free2    = !mv[2] || out_ready;
    e_free1    = !mv[1] || e_free2;
    e_free0    = !mv[0] || e_free1;
    e_out_en   = !flush && mv[1] && e_free2;
    e_s_en     = !flush && mv[0] && e_free1;
    e_in_ready = !flush && e_free0;
    e_in_en    = in_valid && e_in_ready;
    e_occ      = 2'($countones(mv));
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mv    <= '0;
      macc  <= '0;
      mdone <= '0;
      for (int i = 0; i < 3; i++) mt[i] <= '0;
      sb.delete();
    end else begin
      if (mv[2] && out_ready) begin
        mdone <= mdone + 16'd1;
        if (sb.size() > 0) void'(sb.pop_front());
      end
      if (flush) begin
        mv <= '0;
        sb.delete();
      end else begin
        if (e_in_en) begin
          macc <= macc + 16'd1;
          sb.push_back(in_tag);
        end
        mv[2] <= e_out_en || (mv[2] && !out_ready);
        mv[1] <= e_s_en || (mv[1] && !e_out_en);
        mv[0] <= e_in_en || (mv[0] && !e_s_en);
        if (e_out_en) mt[2] <= mt[1];
        if (e_s_en) mt[1] <= mt[0];
        if (e_in_en) mt[0] <= in_tag;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(e_in_ready));
      chk("in_en", 32'(in_en), 32'(e_in_en));
      chk("s_en", 32'(s_en), 32'(e_s_en));
      chk("out_en", 32'(out_en), 32'(e_out_en));
      chk("out_valid", 32'(out_valid), 32'(mv[2]));
      chk("occ", 32'(occ), 32'(e_occ));
      chk("acc_cnt", 32'(acc_cnt), STATS ? 32'(macc) : 32'd0);
      chk("done_cnt", 32'(done_cnt), STATS ? 32'(mdone) : 32'd0);
      if (mv[2]) chk("out_tag", 32'(out_tag), 32'(mt[2]));
      if (mv[2] && out_ready) begin
        if (sb.size() == 0) chk("sb_nonempty", 32'd0, 32'd1);
        else chk("sb_order", 32'(out_tag), 32'(sb[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic iv, input logic [TW-1:0] tg, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_enables", 32'({in_en, s_en, out_en}), 32'd0);
    chk("rst_cnts", 32'({acc_cnt, done_cnt}), 32'd0);

    // Single pair, tag 5.
    cyc(1'b1, 4'h5, 1'b1, 1'b0);
    chk("single_in_en", 32'(in_en), 32'd1);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("single_s_en", 32'({in_en, s_en, out_en}), 32'b010);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("single_out_en", 32'({in_en, s_en, out_en, out_valid}), 32'b0010);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_tag", 32'(out_tag), 32'h5);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("single_done", 32'({out_valid, occ}), 32'd0);

    // Eight back-to-back pairs.
    for (int i = 0; i < 12; i++) begin
      cyc(i < 8, TW'(i), 1'b1, 1'b0);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      chk("b2b_out_valid", 32'(out_valid), 32'(i >= 3 && i <= 10));
      if (i >= 3 && i <= 10) chk("b2b_tag", 32'(out_tag), 32'(i - 3));
      if (i >= 3 && i <= 7) chk("b2b_occ", 32'(occ), 32'd3);
    end
    drain();

    // Fill with tags 1,2,3 and stall.
    for (int i = 1; i <= 3; i++) cyc(1'b1, TW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 4'h4, 1'b0, 1'b0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_enables", 32'({in_en, s_en, out_en}), 32'd0);
      chk("stall_tag", 32'(out_tag), 32'h1);
      chk("stall_occ", 32'(occ), 32'd3);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 4'h0, 1'b1, 1'b0);
      if (i == 1) chk("stall_release_ready", 32'(in_ready), 32'd1);
      chk("stall_drain_valid", 32'(out_valid), 32'd1);
      chk("stall_drain_tag", 32'(out_tag), 32'(i));
    end
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("stall_empty", 32'({out_valid, occ}), 32'd0);

    // Bubble collapse: A, gap, B with consumer stalled.
    cyc(1'b1, 4'hA, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 4'hB, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk("bubble_occ", 32'(occ), 32'd2);
    chk("bubble_head", 32'({out_valid, out_tag}), 32'h1A);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("bubble_first", 32'({out_valid, out_tag}), 32'h1A);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("bubble_second", 32'({out_valid, out_tag}), 32'h1B);
    drain();

    // Flush a full pipe while the producer is offering.
    for (int i = 1; i <= 3; i++) cyc(1'b1, TW'(i + 4), 1'b0, 1'b0);
    cyc(1'b1, 4'h7, 1'b0, 1'b1);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_enables", 32'({in_en, s_en, out_en}), 32'd0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("flush_after", 32'({out_valid, occ}), 32'd0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("flush_no_product", 32'(out_valid), 32'd0);

    // Reset with transactions in flight.
    cyc(1'b1, 4'h9, 1'b0, 1'b0);
    cyc(1'b1, 4'h8, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    chk("midrst_state", 32'({out_valid, occ, acc_cnt, done_cnt}), 32'd0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'h0, 1'b1, 1'b0);
      chk("midrst_no_pulse", 32'(out_valid), 32'd0);
    end

    // Counters: 5 accepted, 3 drained, including simultaneous accept+drain on a full pipe.
    for (int i = 1; i <= 3; i++) cyc(1'b1, TW'(i), 1'b0, 1'b0);
    cyc(1'b1, 4'h4, 1'b1, 1'b0);
    chk("full_all_en", 32'({in_en, s_en, out_en}), 32'b111);
    chk("full_occ", 32'(occ), 32'd3);
    cyc(1'b1, 4'h5, 1'b1, 1'b0);
    chk("full_occ2", 32'(occ), 32'd3);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk("stats_acc", 32'(acc_cnt), STATS ? 32'd5 : 32'd0);
    chk("stats_done", 32'(done_cnt), STATS ? 32'd3 : 32'd0);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk("stats_flush_acc", 32'(acc_cnt), STATS ? 32'd5 : 32'd0);
    chk("stats_flush_done", 32'(done_cnt), STATS ? 32'd3 : 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("stats_rst", 32'({acc_cnt, done_cnt}), 32'd0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    rst = 1'b1;

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 399) != 0);
      in_valid  = $urandom_range(0, 1) != 0;
      in_tag    = TW'($urandom_range(0, 15));
      out_ready = $urandom_range(0, 3) != 0;
      if (n % 500 > 400) out_ready = $urandom_range(0, 3) == 0;
      flush     = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_pipe_ctrl.md
Name: mult_pipe_ctrl

Overview:
- Pipeline controller for the 3-stage registered 4x4 multiplier: drives its in_en / s_en / out_en register enables.
- Valid/ready handshake on both ends, so the multiplier is fed by a streaming producer and drained by a consumer that may stall.
- Carries a sideband tag alongside each operand pair; the tag emerges with the matching product.
- Sits between the operand source and the multiplier datapath; out_valid qualifies the multiplier's pQ.

Parameters:
- TAG_W, 4, width of sideband tag carried per transaction (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline clear, active-high.
- in_valid  in  1  operand pair on multiplier aD/bD is valid.
- in_ready  out  1  controller can accept an operand pair this cycle.
- in_tag  in  TAG_W  tag for the offered operand pair.
- in_en  out  1  multiplier input-register enable.
- s_en  out  1  multiplier stage-register enable.
- out_en  out  1  multiplier output-register enable.
- out_valid  out  1  multiplier pQ holds a valid product.
- out_ready  in  1  consumer accepts product this cycle.
- out_tag  out  TAG_W  tag matching current pQ.
- occ  out  2  number of valid stages, 0..3.
- acc_cnt  out  16  accepted-transaction count (see Optional Feature).
- done_cnt  out  16  completed-transaction count (see Optional Feature).

Behaviour:
- State: valid bits v0 (input regs), v1 (stage regs), v2 (output reg); tag regs t0, t1, t2 load with the same enables.
- Reset (rst=0, async):
  - v0=v1=v2=0, t0..t2=0.
  - Hence in_ready=1, out_valid=0, occ=0, all enables 0, counters 0.
- Combinational enables (flush=0):
  - adv2 = !v2 | out_ready; out_en = v1 & adv2.
  - adv1 = !v1 | adv2; s_en = v0 & adv1.
  - in_ready = !v0 | adv1; in_en = in_valid & in_ready.
- Valid bit update:
  - v2 <= out_en ? 1 : (out_ready ? 0 : v2).
  - v1 <= s_en ? 1 : (out_en ? 0 : v1).
  - v0 <= in_en ? 1 : (s_en ? 0 : v0).
- out_valid = v2; out_tag = t2; occ = v0+v1+v2.
- Latency: pair accepted in cycle k gives out_valid in cycle k+3 when there is no stall.
- Throughput: 1 transaction/cycle sustained while out_ready=1.
- Backpressure:
  - out_ready=0 with v2=1 holds pQ and t2 stable.
  - Bubbles ahead of a stall collapse; once full (occ=3), in_ready=0 until out_ready returns.
  - in_ready recovers in the same cycle out_ready rises (fully combinational ready chain).
- Simultaneous accept + drain on a full pipe: all three enables high; occ stays 3.
- flush=1:
  - Forces in_ready=0 and in_en=s_en=out_en=0.
  - Clears v0..v2 at the edge; tags are not cleared.
  - Flush wins over in_valid/out_ready in the same cycle.
  - The next cycle behaves as post-reset.
- Reset mid-operation: all in-flight transactions dropped, no out_valid pulse.
- in_ready never depends on in_valid (no combinational loop through the producer).

Optional Feature:
- Macro MULT_CTRL_STATS_EN.
- Defined:
  - acc_cnt increments on every in_en cycle.
  - done_cnt increments on every out_valid & out_ready cycle.
  - Both are 16-bit, wrap 0xFFFF->0x0000, cleared by rst, not by flush.
- Undefined: acc_cnt and done_cnt are tied to 0; no counter flops are synthesised.

Decomposition:
- Package mult_pkg:
  - constant MULT_STAGES=3.
  - constant MULT_CNT_W=16.
  - default tag width constant.
- Sub-module mult_vld_stage holds one valid bit plus TAG_W tag register.
  - Inputs: load, clear, vin, tin.
  - Instantiated three times in a chain.

Test Plan:
- Reset then single pair, tag=0x5, out_ready=1: in_en in cycle 0, s_en in cycle 1, out_en in cycle 2; out_valid=1 with out_tag=0x5 in cycle 3 only; occ returns 0.
- 8 back-to-back pairs, tags 0..7, out_ready=1: in_ready stays 1; out_valid high cycles 3..10; tags in order 0..7; occ=3 steady.
- Stall: pipe full (tags 1,2,3), out_ready=0 for 4 cycles: in_ready=0, all enables 0, out_tag=1 held; out_ready=1 gives tags 1,2,3 consecutively, and in_ready=1 in the same cycle.
- Bubble collapse: tag 0xA accepted, out_ready=0, then tag 0xB two cycles later: occ reaches 2, v1 and v2 valid, no loss; drain order A then B.
- flush with occ=3 and in_valid=1: in_ready=0 that cycle; next cycle occ=0, out_valid=0, no product emitted.
- MULT_CTRL_STATS_EN: 5 accepted, 3 drained → acc_cnt=5, done_cnt=3; flush keeps the values; rst zeroes them; without the macro both read 0 throughout.
